// File: rtl/interrupt_ack_controller.sv
// 8259-style interrupt acknowledge controller: rotating fully-nested priority, two-pulse INTA, EOI/AEOI.
// Latency: INT one cycle after an eligible request; latch strobe, vector and EOI mask one cycle after their trigger.
// No backpressure: handshake paced by INTA edges; EOI strobes accepted every cycle. Optional feature: PRIORITY_ROTATE_EN.
module interrupt_ack_controller (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt_request,
  input  logic [7:0] interrupt_mask,
  input  logic [7:0] in_service_register,
  input  logic       interrupt_acknowledge_n,
  input  logic       eoi_command,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  input  logic       auto_eoi,
  input  logic [4:0] vector_base,
  output logic       interrupt_out,
  output logic       latch_in_service,
  output logic [7:0] interrupt,
  output logic [7:0] end_of_interrupt,
  output logic [2:0] priority_rotate,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} state_t;

  state_t     state_q, state_d;
  logic       inta_prev_q;
  logic [2:0] winner_q, winner_d;
  logic       spurious_q, spurious_d;
  logic       int_out_q, int_out_d;
  logic       latch_q, latch_d;
  logic [7:0] intr_q, intr_d;
  logic [7:0] eoi_q, eoi_d;
  logic [7:0] vec_q, vec_d;
  logic       vvalid_q, vvalid_d;
  logic [2:0] rot_q, rot_d;

  logic [7:0] req_unmasked;
  logic [7:0] rot_req, rot_isr, elig_rot;
  logic [3:0] isr_rank;
  logic [2:0] win_rank, win_level, isr_top_level;
  logic       any_elig, isr_nonempty;
  logic       inta_fall, inta_rise;
  logic [7:0] aeoi_mask, cmd_mask;
  logic [2:0] cmd_level;

  function automatic logic [7:0] onehot(input logic [2:0] lvl);
    return 8'b1 << lvl;
  endfunction

  assign req_unmasked = interrupt_request & ~interrupt_mask;
  assign inta_fall    = inta_prev_q & ~interrupt_acknowledge_n;
  assign inta_rise    = ~inta_prev_q & interrupt_acknowledge_n;

  // Rotate request and in-service vectors so that bit 0 is the current highest priority level.
  always_comb begin
    rot_req = '0;
    rot_isr = '0;
    for (int i = 0; i < 8; i++) begin
      rot_req[i] = req_unmasked[rot_q + 3'(i + 1)];
      rot_isr[i] = in_service_register[rot_q + 3'(i + 1)];
    end
  end

  // Rank of the highest in-service level (8 = none) and the best request strictly above it.
  always_comb begin
    isr_rank = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (rot_isr[i]) isr_rank = 4'(i);
    end
    elig_rot = '0;
    for (int i = 0; i < 8; i++) begin
      elig_rot[i] = rot_req[i] && (4'(i) < isr_rank);
    end
    win_rank = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (elig_rot[i]) win_rank = 3'(i);
    end
  end

  assign any_elig      = |elig_rot;
  assign win_level     = rot_q + win_rank + 3'd1;
  assign isr_top_level = rot_q + isr_rank[2:0] + 3'd1;
  assign isr_nonempty  = ~isr_rank[3];

  // Acknowledge sequencing: next state plus the registered strobes it produces.
  always_comb begin
    state_d    = state_q;
    winner_d   = winner_q;
    spurious_d = spurious_q;
    latch_d    = 1'b0;
    intr_d     = '0;
    vvalid_d   = 1'b0;
    vec_d      = '0;
    aeoi_mask  = '0;
    case (state_q)
      IDLE: begin
        // A lone INTA falling edge here is deliberately ignored.
        if (any_elig) state_d = PEND;
      end
      PEND: begin
        if (inta_fall) begin
          state_d    = ACK1;
          spurious_d = ~any_elig;
          winner_d   = any_elig ? win_level : 3'd7;
          latch_d    = any_elig;
          intr_d     = any_elig ? onehot(win_level) : 8'h00;
        end else if (!any_elig) begin
          state_d = IDLE;
        end
      end
      ACK1: begin
        if (inta_rise) state_d = WAIT2;
      end
      WAIT2: begin
        if (inta_fall) state_d = ACK2;
      end
      ACK2: begin
        if (inta_rise) begin
          state_d = IDLE;
          if (auto_eoi && !spurious_q) aeoi_mask = onehot(winner_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == ACK2) begin
      vvalid_d = 1'b1;
      vec_d    = {vector_base, winner_d};
    end
    int_out_d = (state_d == PEND);
  end

  // Command EOI: specific clears eoi_level, non-specific clears the highest in-service level.
  always_comb begin
    cmd_mask  = '0;
    cmd_level = '0;
    if (eoi_command) begin
      if (eoi_specific) begin
        cmd_mask  = onehot(eoi_level);
        cmd_level = eoi_level;
      end else if (isr_nonempty) begin
        cmd_mask  = onehot(isr_top_level);
        cmd_level = isr_top_level;
      end
    end
    eoi_d = cmd_mask | aeoi_mask;
  end

`ifdef PRIORITY_ROTATE_EN
  // The cleared level becomes lowest priority in the same cycle its EOI mask is issued.
  always_comb begin
    rot_d = rot_q;
    if (eoi_command && eoi_rotate && (cmd_mask != 8'h00)) rot_d = cmd_level;
  end
`else
  logic unused_eoi_rotate;
  assign unused_eoi_rotate = eoi_rotate;
  assign rot_d = 3'b111;
`endif

  // State and output registers; reset aborts any acknowledge in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      inta_prev_q <= 1'b1;
      winner_q    <= 3'd7;
      spurious_q  <= 1'b0;
      int_out_q   <= 1'b0;
      latch_q     <= 1'b0;
      intr_q      <= '0;
      eoi_q       <= '0;
      vec_q       <= '0;
      vvalid_q    <= 1'b0;
      rot_q       <= 3'b111;
    end else begin
      state_q     <= state_d;
      inta_prev_q <= interrupt_acknowledge_n;
      winner_q    <= winner_d;
      spurious_q  <= spurious_d;
      int_out_q   <= int_out_d;
      latch_q     <= latch_d;
      intr_q      <= intr_d;
      eoi_q       <= eoi_d;
      vec_q       <= vec_d;
      vvalid_q    <= vvalid_d;
      rot_q       <= rot_d;
    end
  end

  assign interrupt_out    = int_out_q;
  assign latch_in_service = latch_q;
  assign interrupt        = intr_q;
  assign end_of_interrupt = eoi_q;
  assign priority_rotate  = rot_q;
  assign vector_out       = vec_q;
  assign vector_valid     = vvalid_q;

endmodule

// File: tb/tb_interrupt_ack_controller.sv
// Bench for interrupt_ack_controller: directed scenarios with literal expectations, then random traffic.
// Every cycle the DUT outputs are compared against a priority/handshake model kept in the bench.
// Inputs are driven on the falling clock edge; outputs are sampled 1 time unit after the rising edge.
module tb_interrupt_ack_controller;

  logic       clock;
  logic       reset;
  logic [7:0] interrupt_request, interrupt_mask, in_service_register;
  logic       interrupt_acknowledge_n;
  logic       eoi_command, eoi_specific, eoi_rotate, auto_eoi;
  logic [2:0] eoi_level;
  logic [4:0] vector_base;
  logic       interrupt_out, latch_in_service, vector_valid;
  logic [7:0] interrupt, end_of_interrupt, vector_out;
  logic [2:0] priority_rotate;

  int total = 0;
  int bad   = 0;

  interrupt_ack_controller dut (
    .clock(clock), .reset(reset),
    .interrupt_request(interrupt_request), .interrupt_mask(interrupt_mask),
    .in_service_register(in_service_register),
    .interrupt_acknowledge_n(interrupt_acknowledge_n),
    .eoi_command(eoi_command), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .eoi_rotate(eoi_rotate), .auto_eoi(auto_eoi), .vector_base(vector_base),
    .interrupt_out(interrupt_out), .latch_in_service(latch_in_service),
    .interrupt(interrupt), .end_of_interrupt(end_of_interrupt),
    .priority_rotate(priority_rotate), .vector_out(vector_out),
    .vector_valid(vector_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs expected after each rising edge, derived from priority ranks and INTA edge counting.
  bit       m_int_out, m_latch, m_vvalid, m_prev, m_raised, m_spur;
  bit [7:0] m_intr, m_eoi, m_vec;
  bit [2:0] m_rot;
  int       m_edges, m_winner;

  function automatic int rank_of(int lvl, int rot);
    return (lvl - rot - 1 + 16) % 8;
  endfunction

  task automatic model_step();
    bit       fall, rise;
    int       isr_min, best, best_rank, cmd_lvl;
    bit [7:0] cand;
    if (reset) begin
      m_int_out = 0; m_latch = 0; m_vvalid = 0; m_intr = 0; m_eoi = 0; m_vec = 0;
      m_rot = 3'd7; m_prev = 1; m_raised = 0; m_edges = 0; m_spur = 0; m_winner = 7;
      return;
    end
    fall = m_prev && !interrupt_acknowledge_n;
    rise = !m_prev && interrupt_acknowledge_n;
    isr_min = 8;
    for (int l = 0; l < 8; l++)
      if (in_service_register[l] && rank_of(l, m_rot) < isr_min) isr_min = rank_of(l, m_rot);
    cand = interrupt_request & ~interrupt_mask;
    best = -1; best_rank = 8;
    for (int l = 0; l < 8; l++)
      if (cand[l] && rank_of(l, m_rot) < isr_min && rank_of(l, m_rot) < best_rank) begin
        best = l; best_rank = rank_of(l, m_rot);
      end
    m_latch = 0; m_intr = 0; m_eoi = 0; m_vvalid = 0; m_vec = 0;
    if (m_edges == 0) begin
      if (!m_raised) begin
        if (best >= 0) m_raised = 1;
      end else if (fall) begin
        m_raised = 0; m_edges = 1; m_spur = (best < 0);
        m_winner = m_spur ? 7 : best;
        if (!m_spur) begin m_latch = 1; m_intr = 8'(1 << best); end
      end else if (best < 0) begin
        m_raised = 0;
      end
    end else if (m_edges == 1) begin
      if (rise) m_edges = 2;
    end else if (m_edges == 2) begin
      if (fall) begin m_edges = 3; m_vvalid = 1; m_vec = {vector_base, 3'(m_winner)}; end
    end else begin
      if (rise) begin
        m_edges = 0;
        if (auto_eoi && !m_spur) m_eoi = 8'(1 << m_winner);
      end else begin
        m_vvalid = 1; m_vec = {vector_base, 3'(m_winner)};
      end
    end
    m_int_out = m_raised;
    if (eoi_command) begin
      if (eoi_specific) cmd_lvl = int'(eoi_level);
      else if (isr_min < 8) cmd_lvl = (isr_min + int'(m_rot) + 1) % 8;
      else cmd_lvl = -1;
      if (cmd_lvl >= 0) begin
        m_eoi |= 8'(1 << cmd_lvl);
`ifdef PRIORITY_ROTATE_EN
        if (eoi_rotate) m_rot = 3'(cmd_lvl);
`endif
      end
    end
    m_prev = interrupt_acknowledge_n;
  endtask

  always @(posedge clock) begin
    model_step();
    #1;
    check("int_out", {7'b0, interrupt_out}, {7'b0, m_int_out});
    check("latch", {7'b0, latch_in_service}, {7'b0, m_latch});
    check("interrupt", interrupt, m_intr);
    check("eoi", end_of_interrupt, m_eoi);
    check("rotate", {5'b0, priority_rotate}, {5'b0, m_rot});
    check("vector", vector_out, m_vec);
    check("vvalid", {7'b0, vector_valid}, {7'b0, m_vvalid});
  end

  task automatic tick();
    @(negedge clock);
  endtask

  int hold;

  initial begin
    reset = 1; interrupt_request = 0; interrupt_mask = 0; in_service_register = 0;
    interrupt_acknowledge_n = 1; eoi_command = 0; eoi_specific = 0; eoi_level = 0;
    eoi_rotate = 0; auto_eoi = 0; vector_base = 5'h11;
    tick(); tick();
    check("rst_int_out", {7'b0, interrupt_out}, 8'h00);
    check("rst_rotate", {5'b0, priority_rotate}, 8'h07);
    check("rst_vvalid", {7'b0, vector_valid}, 8'h00);
    reset = 0;
    tick();

    // Two INTA pulses acknowledge IR2 (bit 5 is lower priority).
    interrupt_request = 8'h24; tick();
    check("d1_int_out", {7'b0, interrupt_out}, 8'h01);
    interrupt_acknowledge_n = 0; tick();
    check("d1_latch", {7'b0, latch_in_service}, 8'h01);
    check("d1_interrupt", interrupt, 8'h04);
    check("d1_int_low", {7'b0, interrupt_out}, 8'h00);
    interrupt_acknowledge_n = 1; tick();
    check("d1_latch_1cyc", {7'b0, latch_in_service}, 8'h00);
    interrupt_acknowledge_n = 0; tick();
    check("d1_vector", vector_out, 8'h8A);
    check("d1_vvalid", {7'b0, vector_valid}, 8'h01);
    interrupt_acknowledge_n = 1; interrupt_request = 0; tick();
    check("d1_vvalid_off", {7'b0, vector_valid}, 8'h00);
    tick();

    // Nesting: IR3 blocked by IR1 in service, IR0 passes.
    in_service_register = 8'h02; interrupt_request = 8'h08; tick(); tick();
    check("d2_blocked", {7'b0, interrupt_out}, 8'h00);
    interrupt_request = 8'h01; tick();
    check("d2_passes", {7'b0, interrupt_out}, 8'h01);
    interrupt_request = 0; tick();
    check("d2_withdraw", {7'b0, interrupt_out}, 8'h00);
    in_service_register = 0; tick();

    // Auto-EOI on IR7.
    auto_eoi = 1; interrupt_request = 8'h80; tick();
    interrupt_acknowledge_n = 0; tick();
    check("d3_interrupt", interrupt, 8'h80);
    interrupt_acknowledge_n = 1; tick();
    interrupt_acknowledge_n = 0; tick();
    interrupt_acknowledge_n = 1; interrupt_request = 0; tick();
    check("d3_aeoi", end_of_interrupt, 8'h80);
    tick();
    check("d3_aeoi_1cyc", end_of_interrupt, 8'h00);
    auto_eoi = 0;

    // Non-specific rotating EOI with IR1 and IR3 in service.
    in_service_register = 8'h0A; eoi_command = 1; eoi_specific = 0; eoi_rotate = 1; tick();
    eoi_command = 0;
    check("d4_eoi", end_of_interrupt, 8'h02);
`ifdef PRIORITY_ROTATE_EN
    check("d4_rotate", {5'b0, priority_rotate}, 8'h01);
`else
    check("d4_rotate", {5'b0, priority_rotate}, 8'h07);
`endif
    eoi_command = 1; eoi_specific = 1; eoi_level = 3'd7; tick();
    eoi_command = 0;
    check("d4_specific", end_of_interrupt, 8'h80);
    check("d4_rot_back", {5'b0, priority_rotate}, 8'h07);
    in_service_register = 0; eoi_command = 1; eoi_specific = 0; tick();
    eoi_command = 0; eoi_rotate = 0;
    check("d4_empty", end_of_interrupt, 8'h00);

    // Spurious: request withdrawn as INTA falls.
    interrupt_request = 8'h10; tick();
    check("d5_int_out", {7'b0, interrupt_out}, 8'h01);
    interrupt_request = 0; interrupt_acknowledge_n = 0; tick();
    check("d5_no_latch", {7'b0, latch_in_service}, 8'h00);
    check("d5_interrupt", interrupt, 8'h00);
    interrupt_acknowledge_n = 1; tick();
    interrupt_acknowledge_n = 0; tick();
    check("d5_vector", vector_out, 8'h8F);
    interrupt_acknowledge_n = 1; tick();

    // Reset while waiting for the second pulse.
    interrupt_request = 8'h04; tick();
    interrupt_acknowledge_n = 0; tick();
    interrupt_acknowledge_n = 1; tick();
    reset = 1; interrupt_request = 0; tick();
    check("d6_int_out", {7'b0, interrupt_out}, 8'h00);
    check("d6_vector", vector_out, 8'h00);
    check("d6_eoi", end_of_interrupt, 8'h00);
    reset = 0; interrupt_acknowledge_n = 0; tick();
    interrupt_acknowledge_n = 1; tick();
    check("d6_ignored_vv", {7'b0, vector_valid}, 8'h00);
    check("d6_ignored_latch", {7'b0, latch_in_service}, 8'h00);

    // Random traffic against the model.
    hold = 2;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        interrupt_acknowledge_n = ~interrupt_acknowledge_n;
        hold = $urandom_range(1, 4);
      end
      hold--;
      if ($urandom_range(0, 3) == 0) interrupt_request = 8'($urandom);
      if ($urandom_range(0, 15) == 0) interrupt_mask = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) in_service_register = 8'($urandom & $urandom);
      if ($urandom_range(0, 31) == 0) vector_base = 5'($urandom);
      if (c % 200 == 0) auto_eoi = 1'($urandom);
      eoi_command  = ($urandom_range(0, 9) == 0);
      eoi_specific = 1'($urandom);
      eoi_level    = 3'($urandom);
      eoi_rotate   = 1'($urandom);
      reset        = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0; eoi_command = 0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
